// File: rtl/des_round_scheduler.sv
// des_round_scheduler: iterative DES datapath, one Feistel round per clock edge.
// Ports: clk; rst (async, active high); in_valid/in_ready/in_block (64) accept a
//   block; key_idx (4) selects the subkey (48) returned combinationally the same
//   cycle; out_valid/out_ready/out_block (64) deliver the result; busy = not IDLE.
// Build option: define DES_DECRYPT_EN to add the decrypt input (reverse key order).

module initial_permutation (
    input  logic [63:0] blk_i,
    output logic [63:0] blk_o
);
    // DES source bit (1 = MSB) for output position i, MSB first
    function automatic int src(input int i);
        int row;
        int col;
        row = i / 8;
        col = i % 8;
        return ((row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4)) - 8 * col;
    endfunction

    always_comb begin
        blk_o = '0;
        for (int i = 0; i < 64; i++) begin
            blk_o[6'(63 - i)] = blk_i[6'(64 - src(i))];
        end
    end
endmodule

module inv_permutation (
    input  logic [63:0] blk_i,
    output logic [63:0] blk_o
);
    function automatic int src(input int i);
        int row;
        int col;
        row = i / 8;
        col = i % 8;
        return ((row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4)) - 8 * col;
    endfunction

    // Scatter through the forward table to undo it
    always_comb begin
        blk_o = '0;
        for (int i = 0; i < 64; i++) begin
            blk_o[6'(64 - src(i))] = blk_i[6'(63 - i)];
        end
    end
endmodule

module round (
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    input  logic        last_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o
);
    // Each box: 64 nibbles, row-major, row = {b5,b0}, col = b4..b1
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };

    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] f;

    // Expansion: group g takes R bits 4g..4g+5 (1-based, wrapping)
    always_comb begin
        e = '0;
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 6; j++) begin
                e[6'(47 - 6 * g - j)] = r_i[5'(31 - (4 * g + j + 31) % 32)];
            end
        end
    end

    assign x = e ^ k_i;

    always_comb begin
        logic [5:0]   b;
        logic [255:0] t;
        b = '0;
        t = '0;
        s = '0;
        for (int g = 0; g < 8; g++) begin
            b = x[6'(47 - 6 * g) -: 6];
            t = SBOX[g] >> (4 * (63 - int'({b[5], b[0], b[4:1]})));
            s[5'(31 - 4 * g) -: 4] = t[3:0];
        end
    end

    always_comb begin
        f = '0;
        for (int i = 0; i < 32; i++) begin
            f[5'(31 - i)] = s[5'(32 - P_TAB[i])];
        end
    end

    // Final round skips the half swap so {L,R} feeds the output permutation directly
    always_comb begin
        if (last_i) begin
            l_o = l_i ^ f;
            r_o = r_i;
        end else begin
            l_o = r_i;
            r_o = l_i ^ f;
        end
    end
endmodule

module des_round_scheduler #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    output logic [3:0]  key_idx,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        busy
`ifdef DES_DECRYPT_EN
    ,
    input  logic        decrypt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [31:0] l_d;
    logic [31:0] r_d;
    logic [63:0] ip_blk;
    logic        out_valid_q;
    logic        busy_q;

    initial_permutation u_ip (
        .blk_i(in_block),
        .blk_o(ip_blk)
    );

    round u_round (
        .l_i   (l_q),
        .r_i   (r_q),
        .k_i   (subkey),
        .last_i(cnt_q == LAST),
        .l_o   (l_d),
        .r_o   (r_d)
    );

    inv_permutation u_fp (
        .blk_i({l_q, r_q}),
        .blk_o(out_block)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q     <= ip_blk[63:32];
                        r_q     <= ip_blk[31:0];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DES_DECRYPT_EN
    logic dec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            dec_q <= decrypt;
        end
    end
`endif

    always_comb begin
        key_idx = 4'd0;
        if (state_q == RUN) begin
`ifdef DES_DECRYPT_EN
            key_idx = dec_q ? (LAST - cnt_q) : cnt_q;
`else
            key_idx = cnt_q;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_des_round_scheduler.sv
// tb_des_round_scheduler: scoreboard bench for des_round_scheduler,
// using a table-driven DES reference model and key schedule.

module tb_des_round_scheduler;
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25
    };
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
        24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy, decrypt;
    logic [63:0] in_block, out_block;
    logic [3:0]  key_idx;
    logic [47:0] subkey;
    logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready;
    logic        r1_busy, r1_decrypt;
    logic [63:0] r1_in_block, r1_out_block;
    logic [3:0]  r1_key_idx;
    logic [47:0] r1_subkey;

    logic [47:0] ks [16];
    logic [63:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    assign subkey    = ks[key_idx];
    assign r1_subkey = ks[r1_key_idx];

    des_round_scheduler #(.ROUNDS(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .key_idx(key_idx), .subkey(subkey),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy)
`ifdef DES_DECRYPT_EN
        , .decrypt(decrypt)
`endif
    );

    des_round_scheduler #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(r1_in_valid), .in_ready(r1_in_ready),
        .in_block(r1_in_block), .key_idx(r1_key_idx), .subkey(r1_subkey),
        .out_valid(r1_out_valid), .out_ready(r1_out_ready),
        .out_block(r1_out_block), .busy(r1_busy)
`ifdef DES_DECRYPT_EN
        , .decrypt(r1_decrypt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic make_keys(input logic [63:0] key);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] k;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            k = '0;
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
            ks[r] = k;
        end
    endtask

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        int          v;
        e = '0;
        s = '0;
        p = '0;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int g = 0; g < 8; g++) begin
            b = e[47-6*g -: 6];
            v = SB[g][32 * b[5] + 16 * b[0] + int'(b[4:1])];
            s[31-4*g -: 4] = 4'(v);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk,
                                              input int rounds, input logic dec);
        logic [63:0] x;
        logic [63:0] y;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        x = '0;
        y = '0;
        for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < rounds; i++) begin
            t = r;
            r = l ^ ref_f(r, dec ? ks[rounds-1-i] : ks[i]);
            l = t;
        end
        x = {r, l};
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    // Runs one block on the 16-round DUT; call at posedge+1.
    task automatic run_block(input logic [63:0] blk, input logic dec,
                             input int stall, input logic [63:0] exp_blk,
                             input bit hold, output int acc_at);
        int n;
        int r;
        acc_at = -1;
        in_block  = blk;
        in_valid  = 1'b1;
        decrypt   = dec;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", 64'(in_ready), 64'(1));
        if (!in_ready) return;
        @(posedge clk);
        sb_q.push_back(exp_blk);
        #1;
        acc_at = cyc;
        if (!hold) in_valid = 1'b0;
        r = 0;
        while (!out_valid && r < 40) begin
            check("key_idx", 64'(key_idx), 64'(dec ? 15 - r : r));
            check("busy_run", 64'(busy), 64'(1));
            @(posedge clk);
            #1;
            r++;
        end
        check("latency_edges", 64'(r + 1), 64'(17));
        check("key_idx_done", 64'(key_idx), 64'(0));
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_block", out_block, exp_blk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("handshake_valid", 64'(out_valid), 64'(1));
        if (out_valid && sb_q.size() > 0) check("out_block", out_block, sb_q.pop_front());
        @(posedge clk);
        #1;
        check("idle_valid", 64'(out_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        int          acc;
        int          prev;
        logic        dec;
        logic [63:0] blk;
        rst = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        out_ready = 1'b0;
        decrypt = 1'b0;
        r1_in_valid = 1'b0;
        r1_in_block = '0;
        r1_out_ready = 1'b0;
        r1_decrypt = 1'b0;
        make_keys(KAT_KEY);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_key_idx", 64'(key_idx), 64'(0));
        check("rst_out_block", out_block, 64'(0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        run_block(KAT_PT, 1'b0, 0, KAT_CT, 1'b0, acc);
        run_block(KAT_PT, 1'b0, 10, KAT_CT, 1'b0, acc);
`ifdef DES_DECRYPT_EN
        run_block(KAT_CT, 1'b1, 0, KAT_PT, 1'b0, acc);
`endif

        // Reset while round 7 is in flight
        in_block = KAT_PT;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(KAT_CT);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_key_idx", 64'(key_idx), 64'(7));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(0));
        check("mid_rst_key_idx", 64'(key_idx), 64'(0));
        check("mid_rst_block", out_block, 64'(0));
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_release", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        run_block(KAT_PT, 1'b0, 0, KAT_CT, 1'b0, acc);

        // Single-round instance
        r1_in_block = KAT_PT;
        r1_in_valid = 1'b1;
        r1_out_ready = 1'b1;
        check("r1_in_ready", 64'(r1_in_ready), 64'(1));
        @(posedge clk);
        sb_q.push_back(des_model(KAT_PT, 1, 1'b0));
        #1;
        r1_in_valid = 1'b0;
        check("r1_busy_run", 64'(r1_busy), 64'(1));
        check("r1_key_idx", 64'(r1_key_idx), 64'(0));
        check("r1_valid_run", 64'(r1_out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("r1_valid_2edges", 64'(r1_out_valid), 64'(1));
        if (r1_out_valid) check("r1_out_block", r1_out_block, sb_q.pop_front());
        @(posedge clk);
        #1;
        check("r1_idle_busy", 64'(r1_busy), 64'(0));
        r1_out_ready = 1'b0;
        sb_q.delete();

        // Back-to-back random blocks with in_valid held high
        prev = -1;
        for (int i = 0; i < 100; i++) begin
            make_keys({$urandom, $urandom});
            blk = {$urandom, $urandom};
`ifdef DES_DECRYPT_EN
            dec = 1'($urandom_range(0, 1));
`else
            dec = 1'b0;
`endif
            run_block(blk, dec, 0, des_model(blk, 16, dec), 1'b1, acc);
            if (prev >= 0) check("accept_period", 64'(acc - prev), 64'(18));
            prev = acc;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle_busy", 64'(busy), 64'(0));
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
